// File: rtl/acb_mem_arbiter.sv
// acb_mem_arbiter: two-source memory request arbiter with in-order response routing via a tag FIFO
// Ports: clk/reset (sync, active-high);
//   sN_req_write_*  : request pipe from source N (req in, ack out, REQ_W word in)
//   sN_resp_read_*  : response pipe to source N (req in, ack out, RESP_W word out)
//   mem_req_pipe_read_*   : request pipe to memory (req in, ack out, REQ_W word out)
//   mem_resp_pipe_write_* : response pipe from memory (req in, ack out, RESP_W word in)
module acb_mem_arbiter #(
  parameter int REQ_W  = 110,
  parameter int RESP_W = 65,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s0_req_write_req,
  output logic              s0_req_write_ack,
  input  logic [REQ_W-1:0]  s0_req_write_data,
  input  logic              s1_req_write_req,
  output logic              s1_req_write_ack,
  input  logic [REQ_W-1:0]  s1_req_write_data,
  input  logic              s0_resp_read_req,
  output logic              s0_resp_read_ack,
  output logic [RESP_W-1:0] s0_resp_read_data,
  input  logic              s1_resp_read_req,
  output logic              s1_resp_read_ack,
  output logic [RESP_W-1:0] s1_resp_read_data,
  input  logic              mem_req_pipe_read_req,
  output logic              mem_req_pipe_read_ack,
  output logic [REQ_W-1:0]  mem_req_pipe_read_data,
  input  logic              mem_resp_pipe_write_req,
  output logic              mem_resp_pipe_write_ack,
  input  logic [RESP_W-1:0] mem_resp_pipe_write_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  typedef enum logic [1:0] {IDLE, ACCEPT, ISSUE} state_t;
  state_t r_state, w_next;
  logic r_grant, r_last, w_grant, w_src_req, w_push, w_issue, w_pop, w_deliver;
  logic [REQ_W-1:0] r_req_buf;
  logic [DEPTH-1:0] r_tags;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic r_resp_full, r_owner;
  logic [RESP_W-1:0] r_resp_buf;
  // acks come from registered state; reset masks them so nothing transfers while it is held
  assign s0_req_write_ack = !reset && r_state == ACCEPT && !r_grant;
  assign s1_req_write_ack = !reset && r_state == ACCEPT && r_grant;
  assign mem_req_pipe_read_ack = !reset && r_state == ISSUE;
  assign mem_req_pipe_read_data = reset ? '0 : r_req_buf;
  assign mem_resp_pipe_write_ack = !reset && !r_resp_full && r_cnt != '0;
  assign s0_resp_read_ack = !reset && r_resp_full && !r_owner;
  assign s1_resp_read_ack = !reset && r_resp_full && r_owner;
  assign s0_resp_read_data = reset ? '0 : r_resp_buf;
  assign s1_resp_read_data = reset ? '0 : r_resp_buf;
  assign w_src_req = r_grant ? s1_req_write_req : s0_req_write_req;
  assign w_push = (s0_req_write_ack && s0_req_write_req) || (s1_req_write_ack && s1_req_write_req);
  assign w_issue = mem_req_pipe_read_ack && mem_req_pipe_read_req;
  assign w_pop = mem_resp_pipe_write_ack && mem_resp_pipe_write_req;
  assign w_deliver = (s0_resp_read_ack && s0_resp_read_req) || (s1_resp_read_ack && s1_resp_read_req);
  // r_last holds the most recently issued source; on contention the other one wins
  assign w_grant = (s0_req_write_req && s1_req_write_req) ? !r_last : s1_req_write_req;
  always_comb begin
    w_next = r_state == IDLE   ? ((s0_req_write_req || s1_req_write_req) && r_cnt != FULL_CNT ? ACCEPT : IDLE) :
             r_state == ACCEPT ? (w_src_req ? ISSUE : IDLE) :
                                 (w_issue ? IDLE : ISSUE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grant     <= 1'b0;
      r_last      <= 1'b1;
      r_req_buf   <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_resp_full <= 1'b0;
      r_owner     <= 1'b0;
      r_resp_buf  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) r_grant <= w_grant;
      if (w_push) begin
        r_req_buf    <= r_grant ? s1_req_write_data : s0_req_write_data;
        r_tags[r_wp] <= r_grant;
        r_wp         <= r_wp + AW'(1);
      end
      if (w_issue) r_last <= r_grant;
      if (w_pop) begin
        r_rp        <= r_rp + AW'(1);
        r_owner     <= r_tags[r_rp];
        r_resp_buf  <= mem_resp_pipe_write_data;
        r_resp_full <= 1'b1;
      end else if (w_deliver) r_resp_full <= 1'b0;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_acb_mem_arbiter.sv
// tb_acb_mem_arbiter: directed and randomized checks of acb_mem_arbiter against a queue-based model
module tb_acb_mem_arbiter;
  localparam int REQ_W = 110;
  localparam int RESP_W = 65;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset;
  logic s0_req_write_req, s0_req_write_ack, s1_req_write_req, s1_req_write_ack;
  logic [REQ_W-1:0] s0_req_write_data, s1_req_write_data, mem_req_pipe_read_data;
  logic s0_resp_read_req, s0_resp_read_ack, s1_resp_read_req, s1_resp_read_ack;
  logic [RESP_W-1:0] s0_resp_read_data, s1_resp_read_data, mem_resp_pipe_write_data;
  logic mem_req_pipe_read_req, mem_req_pipe_read_ack, mem_resp_pipe_write_req, mem_resp_pipe_write_ack;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  acb_mem_arbiter #(.REQ_W(REQ_W), .RESP_W(RESP_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .s0_req_write_req(s0_req_write_req), .s0_req_write_ack(s0_req_write_ack), .s0_req_write_data(s0_req_write_data),
    .s1_req_write_req(s1_req_write_req), .s1_req_write_ack(s1_req_write_ack), .s1_req_write_data(s1_req_write_data),
    .s0_resp_read_req(s0_resp_read_req), .s0_resp_read_ack(s0_resp_read_ack), .s0_resp_read_data(s0_resp_read_data),
    .s1_resp_read_req(s1_resp_read_req), .s1_resp_read_ack(s1_resp_read_ack), .s1_resp_read_data(s1_resp_read_data),
    .mem_req_pipe_read_req(mem_req_pipe_read_req), .mem_req_pipe_read_ack(mem_req_pipe_read_ack),
    .mem_req_pipe_read_data(mem_req_pipe_read_data),
    .mem_resp_pipe_write_req(mem_resp_pipe_write_req), .mem_resp_pipe_write_ack(mem_resp_pipe_write_ack),
    .mem_resp_pipe_write_data(mem_resp_pipe_write_data)
  );

  function automatic logic [REQ_W-1:0] rnd_req();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[REQ_W-1:0];
  endfunction

  function automatic logic [RESP_W-1:0] rnd_resp();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[RESP_W-1:0];
  endfunction

  task automatic quiet();
    s0_req_write_req = 0; s1_req_write_req = 0; s0_req_write_data = '0; s1_req_write_data = '0;
    s0_resp_read_req = 0; s1_resp_read_req = 0; mem_req_pipe_read_req = 0;
    mem_resp_pipe_write_req = 0; mem_resp_pipe_write_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1;
    repeat (2) step();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    s0_req_write_req = 1; s1_req_write_req = 1; mem_req_pipe_read_req = 1;
    mem_resp_pipe_write_req = 1; s0_resp_read_req = 1; s1_resp_read_req = 1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({s0_req_write_ack, s1_req_write_ack, mem_req_pipe_read_ack, mem_resp_pipe_write_ack, s0_resp_read_ack, s1_resp_read_ack} !== 6'b0) begin
        errors++;
        $display("FAIL reset_acks: got %b%b%b%b%b%b want 000000", s0_req_write_ack, s1_req_write_ack,
                 mem_req_pipe_read_ack, mem_resp_pipe_write_ack, s0_resp_read_ack, s1_resp_read_ack);
      end
      checks++;
      if (mem_req_pipe_read_data !== '0 || s0_resp_read_data !== '0 || s1_resp_read_data !== '0) begin
        errors++;
        $display("FAIL reset_data: got %h %h %h want all zero", mem_req_pipe_read_data, s0_resp_read_data, s1_resp_read_data);
      end
      step();
    end
    quiet();
    reset = 0;
    @(negedge clk);
    checks++;
    if ({s0_req_write_ack, s1_req_write_ack, mem_req_pipe_read_ack, mem_resp_pipe_write_ack, s0_resp_read_ack, s1_resp_read_ack} !== 6'b0) begin
      errors++;
      $display("FAIL post_reset_acks: some ack high, want all 0");
    end
    step();
  endtask

  task automatic test_single();
    logic [REQ_W-1:0] d;
    logic [RESP_W-1:0] r;
    do_reset();
    d = '0;
    d[7:0] = 8'hA5;
    r = 65'h1_2345_6789;
    s0_req_write_data = d; s0_req_write_req = 1; mem_req_pipe_read_req = 1;
    @(negedge clk);
    checks++;
    if (s0_req_write_ack !== 1'b0) begin errors++; $display("FAIL single_t0: s0 ack got %b want 0", s0_req_write_ack); end
    step();
    @(negedge clk);
    checks++;
    if (s0_req_write_ack !== 1'b1 || s1_req_write_ack !== 1'b0) begin
      errors++; $display("FAIL single_t1: s0/s1 ack got %b%b want 10", s0_req_write_ack, s1_req_write_ack);
    end
    step();
    s0_req_write_req = 0;
    @(negedge clk);
    checks++;
    if (mem_req_pipe_read_ack !== 1'b1 || mem_req_pipe_read_data !== d) begin
      errors++; $display("FAIL single_t2: mem ack %b data %h want 1 %h", mem_req_pipe_read_ack, mem_req_pipe_read_data, d);
    end
    step();
    mem_req_pipe_read_req = 0;
    @(negedge clk);
    checks++;
    if (mem_req_pipe_read_ack !== 1'b0) begin errors++; $display("FAIL single_idle: mem ack got %b want 0", mem_req_pipe_read_ack); end
    step();
    mem_resp_pipe_write_req = 1; mem_resp_pipe_write_data = r;
    @(negedge clk);
    checks++;
    if (mem_resp_pipe_write_ack !== 1'b1) begin errors++; $display("FAIL single_resp_ack: got %b want 1", mem_resp_pipe_write_ack); end
    step();
    mem_resp_pipe_write_req = 0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (s0_resp_read_ack !== 1'b1 || s1_resp_read_ack !== 1'b0 || s0_resp_read_data !== r) begin
        errors++; $display("FAIL single_resp: ack %b%b data %h want 10 %h", s0_resp_read_ack, s1_resp_read_ack, s0_resp_read_data, r);
      end
      step();
      s0_resp_read_req = 1;
    end
    s0_resp_read_req = 0;
    @(negedge clk);
    checks++;
    if (s0_resp_read_ack !== 1'b0) begin errors++; $display("FAIL single_drain: s0 resp ack got %b want 0", s0_resp_read_ack); end
    step();
  endtask

  task automatic test_contention();
    logic [REQ_W-1:0] d0, d1;
    int n_acc, n_iss, cyc;
    do_reset();
    d0 = rnd_req(); d1 = rnd_req();
    s0_req_write_data = d0; s1_req_write_data = d1;
    s0_req_write_req = 1; s1_req_write_req = 1; mem_req_pipe_read_req = 1;
    n_acc = 0; n_iss = 0; cyc = 0;
    while (n_iss < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (s0_req_write_ack || s1_req_write_ack) begin
        checks++;
        if ({s1_req_write_ack, s0_req_write_ack} !== ((n_acc % 2) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL contention_grant%0d: s1/s0 ack %b%b want source %0d", n_acc, s1_req_write_ack, s0_req_write_ack, n_acc % 2);
        end
        n_acc++;
      end
      if (mem_req_pipe_read_ack && mem_req_pipe_read_req) begin
        checks++;
        if (mem_req_pipe_read_data !== ((n_iss % 2) ? d1 : d0)) begin
          errors++; $display("FAIL contention_word%0d: got %h want %h", n_iss, mem_req_pipe_read_data, (n_iss % 2) ? d1 : d0);
        end
        n_iss++;
      end
      step();
    end
    checks++;
    if (n_iss != 4) begin errors++; $display("FAIL contention_timeout: issued %0d want 4", n_iss); end
    quiet();
  endtask

  task automatic test_full();
    int n, cyc;
    logic seen;
    do_reset();
    s0_req_write_data = rnd_req(); s0_req_write_req = 1; mem_req_pipe_read_req = 1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (s0_req_write_ack) n++;
      step();
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL full_fill: accepted %0d want 4", n); end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (s0_req_write_ack) seen = 1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL full_block: 5th request acked=%b want 0", seen); end
    mem_resp_pipe_write_req = 1; mem_resp_pipe_write_data = rnd_resp();
    @(negedge clk);
    checks++;
    if (mem_resp_pipe_write_ack !== 1'b1) begin errors++; $display("FAIL full_resp_ack: got %b want 1", mem_resp_pipe_write_ack); end
    step();
    mem_resp_pipe_write_req = 0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (s0_req_write_ack) seen = 1;
      step();
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL full_release: 5th acked=%b want 1 within 2 cycles", seen); end
    quiet();
  endtask

  task automatic test_order();
    logic [RESP_W-1:0] ra, rb;
    int cyc;
    do_reset();
    ra = rnd_resp(); rb = rnd_resp();
    mem_req_pipe_read_req = 1;
    s1_req_write_req = 1; s1_req_write_data = rnd_req();
    cyc = 0;
    @(negedge clk);
    while (!s1_req_write_ack && cyc < 10) begin @(negedge clk); cyc++; end
    checks++;
    if (s1_req_write_ack !== 1'b1) begin errors++; $display("FAIL order_s1_accept: got %b want 1", s1_req_write_ack); end
    step();
    s1_req_write_req = 0; s0_req_write_req = 1; s0_req_write_data = rnd_req();
    cyc = 0;
    @(negedge clk);
    while (!s0_req_write_ack && cyc < 10) begin @(negedge clk); cyc++; end
    checks++;
    if (s0_req_write_ack !== 1'b1) begin errors++; $display("FAIL order_s0_accept: got %b want 1", s0_req_write_ack); end
    step();
    s0_req_write_req = 0;
    repeat (3) step();
    s0_resp_read_req = 1; s1_resp_read_req = 0;
    mem_resp_pipe_write_req = 1; mem_resp_pipe_write_data = ra;
    @(negedge clk);
    checks++;
    if (mem_resp_pipe_write_ack !== 1'b1) begin errors++; $display("FAIL order_first_ack: got %b want 1", mem_resp_pipe_write_ack); end
    step();
    mem_resp_pipe_write_data = rb;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (s1_resp_read_ack !== 1'b1 || s0_resp_read_ack !== 1'b0 || s1_resp_read_data !== ra || mem_resp_pipe_write_ack !== 1'b0) begin
        errors++; $display("FAIL order_hold: s1/s0 ack %b%b data %h memack %b want 10 %h 0",
                           s1_resp_read_ack, s0_resp_read_ack, s1_resp_read_data, mem_resp_pipe_write_ack, ra);
      end
      step();
    end
    s1_resp_read_req = 1;
    @(negedge clk);
    checks++;
    if (s1_resp_read_ack !== 1'b1) begin errors++; $display("FAIL order_s1_read: got %b want 1", s1_resp_read_ack); end
    step();
    s1_resp_read_req = 0;
    @(negedge clk);
    checks++;
    if (mem_resp_pipe_write_ack !== 1'b1 || s0_resp_read_ack !== 1'b0) begin
      errors++; $display("FAIL order_second_ack: memack %b s0ack %b want 1 0", mem_resp_pipe_write_ack, s0_resp_read_ack);
    end
    step();
    mem_resp_pipe_write_req = 0; s0_resp_read_req = 0;
    @(negedge clk);
    checks++;
    if (s0_resp_read_ack !== 1'b1 || s1_resp_read_ack !== 1'b0 || s0_resp_read_data !== rb) begin
      errors++; $display("FAIL order_second_route: s0/s1 ack %b%b data %h want 10 %h", s0_resp_read_ack, s1_resp_read_ack, s0_resp_read_data, rb);
    end
    step();
    quiet();
  endtask

  task automatic test_spurious();
    do_reset();
    mem_resp_pipe_write_req = 1; mem_resp_pipe_write_data = rnd_resp();
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (mem_resp_pipe_write_ack !== 1'b0 || s0_resp_read_ack !== 1'b0 || s1_resp_read_ack !== 1'b0) begin
        errors++; $display("FAIL spurious: memack %b s0 %b s1 %b want 0 0 0", mem_resp_pipe_write_ack, s0_resp_read_ack, s1_resp_read_ack);
      end
      step();
    end
    quiet();
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    mem_req_pipe_read_req = 1;
    s0_req_write_req = 1; s0_req_write_data = rnd_req();
    cyc = 0;
    @(negedge clk);
    while (!s0_req_write_ack && cyc < 10) begin @(negedge clk); cyc++; end
    step();
    s0_req_write_req = 0;
    @(negedge clk);
    checks++;
    if (mem_req_pipe_read_ack !== 1'b1) begin errors++; $display("FAIL rmid_s0_issue: got %b want 1", mem_req_pipe_read_ack); end
    step();
    mem_req_pipe_read_req = 0;
    s1_req_write_req = 1; s1_req_write_data = rnd_req();
    cyc = 0;
    @(negedge clk);
    while (!s1_req_write_ack && cyc < 10) begin @(negedge clk); cyc++; end
    checks++;
    if (s1_req_write_ack !== 1'b1) begin errors++; $display("FAIL rmid_s1_accept: got %b want 1", s1_req_write_ack); end
    step();
    s1_req_write_req = 0;
    @(negedge clk);
    checks++;
    if (mem_req_pipe_read_ack !== 1'b1) begin errors++; $display("FAIL rmid_in_issue: got %b want 1", mem_req_pipe_read_ack); end
    step();
    reset = 1;
    mem_req_pipe_read_req = 1; mem_resp_pipe_write_req = 1; s0_req_write_req = 1; s1_req_write_req = 1;
    @(negedge clk);
    checks++;
    if ({s0_req_write_ack, s1_req_write_ack, mem_req_pipe_read_ack, mem_resp_pipe_write_ack} !== 4'b0) begin
      errors++; $display("FAIL rmid_during: acks %b%b%b%b want 0000", s0_req_write_ack, s1_req_write_ack, mem_req_pipe_read_ack, mem_resp_pipe_write_ack);
    end
    step();
    reset = 0;
    @(negedge clk);
    checks++;
    if ({s0_req_write_ack, s1_req_write_ack, mem_req_pipe_read_ack, mem_resp_pipe_write_ack} !== 4'b0) begin
      errors++; $display("FAIL rmid_after: acks %b%b%b%b want 0000 (fifo empty)", s0_req_write_ack, s1_req_write_ack, mem_req_pipe_read_ack, mem_resp_pipe_write_ack);
    end
    step();
    @(negedge clk);
    checks++;
    if (s0_req_write_ack !== 1'b1 || s1_req_write_ack !== 1'b0) begin
      errors++; $display("FAIL rmid_priority: s0/s1 ack %b%b want 10", s0_req_write_ack, s1_req_write_ack);
    end
    step();
    quiet();
  endtask

  task automatic test_random();
    bit q_own[$];
    logic [REQ_W-1:0] q_word[$];
    bit held, h_own, acc0, acc1, pop, dlv;
    logic [RESP_W-1:0] h_data;
    int n_iss, n_dlv;
    do_reset();
    held = 0; h_own = 0; h_data = '0; n_iss = 0; n_dlv = 0;
    for (int c = 0; c < 3000; c++) begin
      s0_req_write_req = $urandom_range(0, 2) != 0; s0_req_write_data = rnd_req();
      s1_req_write_req = $urandom_range(0, 2) != 0; s1_req_write_data = rnd_req();
      mem_req_pipe_read_req = $urandom_range(0, 3) != 0;
      mem_resp_pipe_write_req = $urandom_range(0, 2) == 0; mem_resp_pipe_write_data = rnd_resp();
      s0_resp_read_req = $urandom_range(0, 1) != 0;
      s1_resp_read_req = $urandom_range(0, 1) != 0;
      @(negedge clk);
      checks++;
      if (mem_resp_pipe_write_ack !== (!held && q_own.size() > 0)) begin
        errors++; $display("FAIL rnd_memresp_ack c%0d: got %b want %b", c, mem_resp_pipe_write_ack, !held && q_own.size() > 0);
      end
      checks++;
      if ({s1_resp_read_ack, s0_resp_read_ack} !== (held ? (h_own ? 2'b10 : 2'b01) : 2'b00)) begin
        errors++; $display("FAIL rnd_resp_route c%0d: s1/s0 ack %b%b held %b owner %b", c, s1_resp_read_ack, s0_resp_read_ack, held, h_own);
      end
      if (held) begin
        checks++;
        if (s0_resp_read_data !== h_data || s1_resp_read_data !== h_data) begin
          errors++; $display("FAIL rnd_resp_data c%0d: got %h/%h want %h", c, s0_resp_read_data, s1_resp_read_data, h_data);
        end
      end
      checks++;
      if (s0_req_write_ack && s1_req_write_ack) begin errors++; $display("FAIL rnd_dual_grant c%0d: both source acks 1 want one", c); end
      if (mem_req_pipe_read_ack && mem_req_pipe_read_req) begin
        checks++;
        if (q_word.size() == 0 || mem_req_pipe_read_data !== q_word[0]) begin
          errors++; $display("FAIL rnd_issue c%0d: got %h want %h", c, mem_req_pipe_read_data, q_word.size() ? q_word[0] : '0);
        end
        if (q_word.size() > 0) void'(q_word.pop_front());
        n_iss++;
      end
      acc0 = s0_req_write_ack && s0_req_write_req;
      acc1 = s1_req_write_ack && s1_req_write_req;
      pop = mem_resp_pipe_write_ack && mem_resp_pipe_write_req;
      dlv = held && (h_own ? s1_resp_read_req : s0_resp_read_req);
      if (acc0 || acc1) begin
        checks++;
        if (q_own.size() >= DEPTH || q_word.size() != 0) begin
          errors++; $display("FAIL rnd_accept c%0d: outstanding %0d unissued %0d want <%0d and 0", c, q_own.size(), q_word.size(), DEPTH);
        end
      end
      if (pop && q_own.size() > 0) begin
        held = 1; h_own = q_own.pop_front(); h_data = mem_resp_pipe_write_data;
      end else if (dlv) begin
        held = 0; n_dlv++;
      end
      if (acc0) begin q_own.push_back(1'b0); q_word.push_back(s0_req_write_data); end
      if (acc1) begin q_own.push_back(1'b1); q_word.push_back(s1_req_write_data); end
      step();
    end
    checks++;
    if (n_iss < 100 || n_dlv < 100) begin errors++; $display("FAIL rnd_progress: issued %0d delivered %0d want >=100 each", n_iss, n_dlv); end
    quiet();
  endtask

  initial begin
    quiet();
    reset = 1;
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_order();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
